sparsity_sample_collector: RTL and testbench

Producer side of the sparsity sample interface. Taps an activation/weight stream, counts non-zero and total elements per programmable sample length, and emits one-cycle `sample_valid` pulses carrying `nonzero_count`/`total_count` to the adaptive sparsity mode FSM. Sits between the datapath stream tap and the FSM's sample inputs. It never back-pressures the stream.

---
 rtl/sparsity_sample_collector.sv | 137 +++++++++++++
 tb/tb_sparsity_sample_collector.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/sparsity_sample_collector.sv
// sparsity_sample_collector
//   Taps an activation/weight stream and counts non-zero and total elements
//   over a programmable sample length. Each closed sample raises sample_valid
//   for one cycle and presents the counts to the adaptive sparsity mode FSM.
//   The block never back-pressures the stream.
//
// Ports
//   clk, reset        rising-edge clock; synchronous active-high reset
//   enable            low: beats are ignored and the accumulators hold
//   in_valid          beat qualifier
//   in_data           LANES elements; lane i at [i*ELEM_W +: ELEM_W], signed
//   in_lane_mask      1 = lane carries a real element
//   zero_thresh       unsigned magnitude; |x| <= zero_thresh counts as zero
//   sample_len        elements per sample (0 behaves as 1)
//   flush             close a partial sample
//   sample_valid      one-cycle pulse per closed sample
//   nonzero_count     saturated non-zero count, held from the last pulse
//   total_count       saturated element count, held from the last pulse
//   samples_emitted   wrapping pulse counter
//   busy              accumulator non-empty

// Per-lane classifier: is this lane a real, non-zero element?
module sparsity_lane #(
  parameter int ELEM_W = 8
) (
  input  logic [ELEM_W-1:0] elem,
  input  logic              mask,
  input  logic [ELEM_W-1:0] zero_thresh,
  output logic              nz
);
  logic [ELEM_W:0] ext;
  logic [ELEM_W:0] mag;

  // One extra bit so the most negative value has a representable magnitude.
  assign ext = {elem[ELEM_W-1], elem};
  assign mag = elem[ELEM_W-1] ? (~ext + 1'b1) : ext;
  assign nz  = mask && (mag > {1'b0, zero_thresh});
endmodule

module sparsity_sample_collector #(
  parameter int LANES  = 8,
  parameter int ELEM_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    in_valid,
  input  logic [LANES*ELEM_W-1:0] in_data,
  input  logic [LANES-1:0]        in_lane_mask,
  input  logic [ELEM_W-1:0]       zero_thresh,
  input  logic [CNT_W-1:0]        sample_len,
  input  logic                    flush,
  output logic                    sample_valid,
  output logic [CNT_W-1:0]        nonzero_count,
  output logic [CNT_W-1:0]        total_count,
  output logic [15:0]             samples_emitted,
  output logic                    busy
);
  // One headroom bit: an accumulator below 2^CNT_W plus one beat always fits,
  // so overflow past the output width is visible in the top bit.
  localparam int AW = CNT_W + 1;

  typedef enum logic {EMPTY, ACCUM} state_t;

  state_t                        state;
  logic [AW-1:0]                 tot_acc, nz_acc;
  logic [AW-1:0]                 act, nzb, act_eff, nzb_eff;
  logic [AW-1:0]                 tot_n, nz_n, len_eff;
  logic                          accepted, close;
  logic [LANES-1:0][ELEM_W-1:0]  elems;
  logic [LANES-1:0]              lane_nz;

  assign elems = in_data;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    sparsity_lane #(.ELEM_W(ELEM_W)) u_lane (
      .elem        (elems[g]),
      .mask        (in_lane_mask[g]),
      .zero_thresh (zero_thresh),
      .nz          (lane_nz[g])
    );
  end

  always_comb begin
    act = '0;
    nzb = '0;
    for (int i = 0; i < LANES; i++) begin
      act = act + AW'(in_lane_mask[i]);
      nzb = nzb + AW'(lane_nz[i]);
    end
  end

  assign accepted = enable & in_valid;
  assign act_eff  = accepted ? act : '0;
  assign nzb_eff  = accepted ? nzb : '0;
  assign tot_n    = tot_acc + act_eff;
  assign nz_n     = nz_acc + nzb_eff;
  assign len_eff  = (sample_len == '0) ? AW'(1) : {1'b0, sample_len};

  // A sample exceeding 2^CNT_W-1 also satisfies tot_n >= len_eff, so the
  // saturation close needs no separate term.
  assign close = (accepted && (act != '0) && (tot_n >= len_eff)) ||
                 (flush && (tot_n != '0));

  function automatic logic [CNT_W-1:0] sat(input logic [AW-1:0] v);
    return v[CNT_W] ? {CNT_W{1'b1}} : v[CNT_W-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= EMPTY;
      tot_acc         <= '0;
      nz_acc          <= '0;
      sample_valid    <= 1'b0;
      nonzero_count   <= '0;
      total_count     <= '0;
      samples_emitted <= '0;
    end else begin
      sample_valid <= close;
      if (close) begin
        nonzero_count   <= sat(nz_n);
        total_count     <= sat(tot_n);
        samples_emitted <= samples_emitted + 16'd1;
        tot_acc         <= '0;
        nz_acc          <= '0;
        state           <= EMPTY;
      end else begin
        tot_acc <= tot_n;
        nz_acc  <= nz_n;
        state   <= (tot_n != '0) ? ACCUM : EMPTY;
      end
    end
  end

  assign busy = (state == ACCUM);
endmodule

// File: tb/tb_sparsity_sample_collector.sv
module tb_sparsity_sample_collector;
  logic        clk = 1'b0;
  logic        reset, enable, in_valid, flush;
  logic [63:0] in_data;
  logic [7:0]  in_lane_mask, zero_thresh;
  logic [15:0] sample_len;
  logic        sample_valid, busy;
  logic [15:0] nonzero_count, total_count, samples_emitted;

  logic        enable8;
  logic [7:0]  sample_len8, nz8, tot8;
  logic        sv8, busy8;
  logic [15:0] emitted8;

  int n_cmp = 0;
  int n_bad = 0;
  int pulses = 0;
  int pulses8 = 0;

  localparam logic [63:0] D6   = 64'h0000_0101_0101_0101; // six non-zero lanes
  localparam logic [63:0] DALL = 64'h0101_0101_0101_0101;
  localparam logic [63:0] DTH  = 64'h7F80_02FD_03FE_0100; // {0,1,-2,3,-3,2,-128,127}

  always #5 clk = ~clk;

  sparsity_sample_collector #(.LANES(8), .ELEM_W(8), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid),
    .in_data(in_data), .in_lane_mask(in_lane_mask), .zero_thresh(zero_thresh),
    .sample_len(sample_len), .flush(flush), .sample_valid(sample_valid),
    .nonzero_count(nonzero_count), .total_count(total_count),
    .samples_emitted(samples_emitted), .busy(busy));

  sparsity_sample_collector #(.LANES(8), .ELEM_W(8), .CNT_W(8)) dut8 (
    .clk(clk), .reset(reset), .enable(enable8), .in_valid(in_valid),
    .in_data(in_data), .in_lane_mask(in_lane_mask), .zero_thresh(zero_thresh),
    .sample_len(sample_len8), .flush(flush), .sample_valid(sv8),
    .nonzero_count(nz8), .total_count(tot8),
    .samples_emitted(emitted8), .busy(busy8));

  always @(posedge clk) begin
    #1;
    if (sample_valid) pulses++;
    if (sv8) pulses8++;
  end

  // One cycle of stimulus, applied at a falling edge; returns at the next
  // falling edge with the resulting outputs settled.
  task automatic step(input logic v, input logic [7:0] m, input logic [63:0] d,
                      input logic f);
    in_valid = v; in_lane_mask = m; in_data = d; flush = f;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (sample_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %0b want 0", sample_valid); end
    n_cmp++; if (nonzero_count !== 16'd0) begin n_bad++; $display("FAIL reset_nz: got %0d want 0", nonzero_count); end
    n_cmp++; if (total_count !== 16'd0) begin n_bad++; $display("FAIL reset_tot: got %0d want 0", total_count); end
    n_cmp++; if (samples_emitted !== 16'd0) begin n_bad++; $display("FAIL reset_emitted: got %0d want 0", samples_emitted); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %0b want 0", busy); end
  endtask

  task automatic test_basic();
    sample_len = 16; zero_thresh = 0;
    step(1, 8'hFF, D6, 0);
    n_cmp++; if (sample_valid !== 1'b0) begin n_bad++; $display("FAIL basic_early: got %0b want 0", sample_valid); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy: got %0b want 1", busy); end
    step(1, 8'hFF, D6, 0);
    n_cmp++; if (sample_valid !== 1'b1) begin n_bad++; $display("FAIL basic_valid: got %0b want 1", sample_valid); end
    n_cmp++; if (nonzero_count !== 16'd12) begin n_bad++; $display("FAIL basic_nz: got %0d want 12", nonzero_count); end
    n_cmp++; if (total_count !== 16'd16) begin n_bad++; $display("FAIL basic_tot: got %0d want 16", total_count); end
    n_cmp++; if (samples_emitted !== 16'd1) begin n_bad++; $display("FAIL basic_emitted: got %0d want 1", samples_emitted); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL basic_busy_clr: got %0b want 0", busy); end
    step(0, 8'h00, 64'd0, 0);
    n_cmp++; if (sample_valid !== 1'b0 || nonzero_count !== 16'd12) begin
      n_bad++; $display("FAIL basic_hold: got valid=%0b nz=%0d want 0/12", sample_valid, nonzero_count); end
  endtask

  task automatic test_zero_thresh();
    sample_len = 8; zero_thresh = 2;
    step(1, 8'hFF, DTH, 0);
    n_cmp++; if (sample_valid !== 1'b1) begin n_bad++; $display("FAIL thresh_valid: got %0b want 1", sample_valid); end
    n_cmp++; if (nonzero_count !== 16'd4) begin n_bad++; $display("FAIL thresh_nz: got %0d want 4", nonzero_count); end
    n_cmp++; if (total_count !== 16'd8) begin n_bad++; $display("FAIL thresh_tot: got %0d want 8", total_count); end
    zero_thresh = 0;
  endtask

  task automatic test_overshoot();
    sample_len = 10;
    step(1, 8'hFF, DALL, 0);
    step(1, 8'h00, DALL, 0);
    n_cmp++; if (sample_valid !== 1'b0 || busy !== 1'b1) begin
      n_bad++; $display("FAIL over_mask0: got valid=%0b busy=%0b want 0/1", sample_valid, busy); end
    step(1, 8'h0F, DALL, 0);
    n_cmp++; if (sample_valid !== 1'b1) begin n_bad++; $display("FAIL over_valid: got %0b want 1", sample_valid); end
    n_cmp++; if (nonzero_count !== 16'd12) begin n_bad++; $display("FAIL over_nz: got %0d want 12", nonzero_count); end
    n_cmp++; if (total_count !== 16'd12) begin n_bad++; $display("FAIL over_tot: got %0d want 12", total_count); end
    n_cmp++; if (samples_emitted !== 16'd3) begin n_bad++; $display("FAIL over_emitted: got %0d want 3", samples_emitted); end
  endtask

  task automatic test_flush();
    sample_len = 100;
    repeat (3) step(1, 8'hFF, D6, 0);
    step(0, 8'h00, 64'd0, 1);
    n_cmp++; if (sample_valid !== 1'b1) begin n_bad++; $display("FAIL flush_valid: got %0b want 1", sample_valid); end
    n_cmp++; if (nonzero_count !== 16'd18) begin n_bad++; $display("FAIL flush_nz: got %0d want 18", nonzero_count); end
    n_cmp++; if (total_count !== 16'd24) begin n_bad++; $display("FAIL flush_tot: got %0d want 24", total_count); end
    step(0, 8'h00, 64'd0, 1);
    n_cmp++; if (sample_valid !== 1'b0) begin n_bad++; $display("FAIL flush_empty: got %0b want 0", sample_valid); end
    step(1, 8'hFF, D6, 1);
    n_cmp++; if (sample_valid !== 1'b1 || total_count !== 16'd8 || nonzero_count !== 16'd6) begin
      n_bad++; $display("FAIL flush_with_beat: got valid=%0b tot=%0d nz=%0d want 1/8/6", sample_valid, total_count, nonzero_count); end
    n_cmp++; if (samples_emitted !== 16'd5) begin n_bad++; $display("FAIL flush_emitted: got %0d want 5", samples_emitted); end
  endtask

  task automatic test_enable();
    int p0;
    sample_len = 16;
    step(1, 8'hFF, D6, 0);
    enable = 0;
    p0 = pulses;
    repeat (4) step(1, 8'hFF, D6, 0);
    n_cmp++; if (pulses !== p0 || busy !== 1'b1) begin
      n_bad++; $display("FAIL en_hold: got pulses=%0d busy=%0b want %0d/1", pulses, busy, p0); end
    step(0, 8'h00, 64'd0, 1);
    n_cmp++; if (sample_valid !== 1'b1 || total_count !== 16'd8 || nonzero_count !== 16'd6) begin
      n_bad++; $display("FAIL en_flush: got valid=%0b tot=%0d nz=%0d want 1/8/6", sample_valid, total_count, nonzero_count); end
    enable = 1;
  endtask

  task automatic test_len_lower();
    sample_len = 100;
    step(1, 8'hFF, DALL, 0);
    sample_len = 4;
    step(1, 8'hFF, DALL, 0);
    n_cmp++; if (sample_valid !== 1'b1 || total_count !== 16'd16) begin
      n_bad++; $display("FAIL len_lower: got valid=%0b tot=%0d want 1/16", sample_valid, total_count); end
  endtask

  task automatic test_reset_mid();
    int p0;
    sample_len = 64;
    repeat (5) step(1, 8'hFF, DALL, 0);
    do_reset();
    n_cmp++; if (sample_valid !== 1'b0 || busy !== 1'b0 || total_count !== 16'd0 ||
                 nonzero_count !== 16'd0 || samples_emitted !== 16'd0) begin
      n_bad++; $display("FAIL rst_mid_clear: got v=%0b b=%0b tot=%0d nz=%0d em=%0d want all 0",
                        sample_valid, busy, total_count, nonzero_count, samples_emitted); end
    step(0, 8'h00, 64'd0, 0);
    n_cmp++; if (sample_valid !== 1'b0) begin n_bad++; $display("FAIL rst_mid_nopulse: got %0b want 0", sample_valid); end
    p0 = pulses;
    repeat (7) step(1, 8'hFF, DALL, 0);
    n_cmp++; if (pulses !== p0) begin n_bad++; $display("FAIL rst_mid_early: got %0d pulses want 0", pulses - p0); end
    step(1, 8'hFF, DALL, 0);
    n_cmp++; if (sample_valid !== 1'b1 || total_count !== 16'd64 || nonzero_count !== 16'd64) begin
      n_bad++; $display("FAIL rst_mid_full: got v=%0b tot=%0d nz=%0d want 1/64/64", sample_valid, total_count, nonzero_count); end
  endtask

  task automatic test_back_to_back();
    sample_len = 0;
    step(1, 8'h07, DALL, 0);
    n_cmp++; if (sample_valid !== 1'b1 || total_count !== 16'd3) begin
      n_bad++; $display("FAIL len0_a: got v=%0b tot=%0d want 1/3", sample_valid, total_count); end
    step(1, 8'h81, DALL, 0);
    n_cmp++; if (sample_valid !== 1'b1 || total_count !== 16'd2 || nonzero_count !== 16'd2) begin
      n_bad++; $display("FAIL len0_b: got v=%0b tot=%0d nz=%0d want 1/2/2", sample_valid, total_count, nonzero_count); end
    step(1, 8'h00, DALL, 0);
    n_cmp++; if (sample_valid !== 1'b0) begin n_bad++; $display("FAIL len0_mask0: got %0b want 0", sample_valid); end
  endtask

  task automatic test_saturation();
    enable = 0; enable8 = 1; sample_len8 = 8'd255;
    repeat (31) step(1, 8'hFF, DALL, 0);
    n_cmp++; if (pulses8 !== 0) begin n_bad++; $display("FAIL sat_early: got %0d pulses want 0", pulses8); end
    step(1, 8'hFF, DALL, 0);
    n_cmp++; if (sv8 !== 1'b1 || tot8 !== 8'd255 || nz8 !== 8'd255) begin
      n_bad++; $display("FAIL sat_clamp: got v=%0b tot=%0d nz=%0d want 1/255/255", sv8, tot8, nz8); end
    n_cmp++; if (emitted8 !== 16'd1 || busy8 !== 1'b0) begin
      n_bad++; $display("FAIL sat_state: got em=%0d busy=%0b want 1/0", emitted8, busy8); end
    enable = 1; enable8 = 0;
  endtask

  task automatic test_wrap();
    do_reset();
    sample_len = 0;
    repeat (65535) step(1, 8'h01, DALL, 0);
    n_cmp++; if (samples_emitted !== 16'hFFFF) begin n_bad++; $display("FAIL wrap_top: got %0h want ffff", samples_emitted); end
    step(1, 8'h01, DALL, 0);
    n_cmp++; if (samples_emitted !== 16'h0000 || sample_valid !== 1'b1) begin
      n_bad++; $display("FAIL wrap_zero: got em=%0h v=%0b want 0/1", samples_emitted, sample_valid); end
  endtask

  initial begin
    reset = 1; enable = 1; enable8 = 0; in_valid = 0; flush = 0;
    in_data = '0; in_lane_mask = '0; zero_thresh = '0;
    sample_len = 16'd1; sample_len8 = 8'd1;
    @(negedge clk);
    test_reset();
    test_basic();
    test_zero_thresh();
    test_overshoot();
    test_flush();
    test_enable();
    test_len_lower();
    test_reset_mid();
    test_back_to_back();
    test_saturation();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
